// File: rtl/period_filter.sv
`default_nettype none
// ============================================================================
//  Module      : period_filter
//  Description : Range gate, outlier rejection, 2^AVG_LOG2-deep moving average
//                and lock detection for raw periods from the frequency counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module period_filter #(
  parameter int PERIOD_W       = 32,
  parameter int AVG_LOG2       = 2,
  parameter int MIN_PERIOD     = 16,
  parameter int MAX_PERIOD     = 65535,
  parameter int TOL_SHIFT      = 3,
  parameter int LOCK_COUNT     = 4,
  parameter int MISS_LIMIT     = 3,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_period_valid,
  input  logic [PERIOD_W-1:0] i_period_in,
  output logic                o_avg_valid,
  output logic [PERIOD_W-1:0] o_avg_period,
  output logic                o_locked,
  output logic [1:0]          o_state,
  output logic [15:0]         o_reject_count
);

  localparam int c_N      = 1 << AVG_LOG2;
  localparam int c_SUM_W  = PERIOD_W + AVG_LOG2;
  localparam int c_FILL_W = AVG_LOG2 + 1;
  localparam int c_RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int c_MISS_W = $clog2(MISS_LIMIT + 1);
  localparam int c_TO_W   = $clog2(TIMEOUT_CYCLES);

  localparam logic [c_FILL_W-1:0] c_FILL_LAST = c_FILL_W'(c_N - 1);
  localparam logic [c_RUN_W-1:0]  c_RUN_LAST  = c_RUN_W'(LOCK_COUNT - 1);
  localparam logic [c_MISS_W-1:0] c_MISS_LAST = c_MISS_W'(MISS_LIMIT - 1);
  localparam logic [c_TO_W-1:0]   c_TO_LAST   = c_TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_TRACK  = 2'd2,
    S_LOCKED = 2'd3
  } state_t;

  state_t               r_state, w_state_next;
  logic [PERIOD_W-1:0]  r_buf [c_N];
  logic [AVG_LOG2-1:0]  r_wptr, w_wptr_next;
  logic [c_SUM_W-1:0]   r_sum, w_sum_next;
  logic [c_FILL_W-1:0]  r_fill, w_fill_next;
  logic [c_RUN_W-1:0]   r_run, w_run_next;
  logic [c_MISS_W-1:0]  r_miss, w_miss_next;
  logic [c_TO_W-1:0]    r_timeout, w_timeout_next;
  logic [PERIOD_W-1:0]  r_avg, w_avg_next;
  logic                 w_avg_valid_next;
  logic [15:0]          r_reject_count, w_reject_next;
  logic                 r_avg_valid, r_locked;
  logic                 w_buf_we;

  logic                 w_in_range, w_dev_ok, w_accept;
  logic [PERIOD_W:0]    w_diff, w_tol;
  logic [PERIOD_W-1:0]  w_oldest;
  logic [c_SUM_W-1:0]   w_sum_add, w_sum_roll;

  assign w_oldest   = r_buf[r_wptr];
  assign w_in_range = (i_period_in >= PERIOD_W'(MIN_PERIOD)) &&
                      (i_period_in <= PERIOD_W'(MAX_PERIOD));
  // Absolute deviation held one bit wider so neither direction can wrap.
  assign w_diff     = (i_period_in >= r_avg) ? ({1'b0, i_period_in} - {1'b0, r_avg})
                                             : ({1'b0, r_avg} - {1'b0, i_period_in});
  assign w_tol      = {1'b0, r_avg >> TOL_SHIFT};
  assign w_dev_ok   = (w_diff <= w_tol);
  assign w_accept   = w_in_range &&
                      (((r_state != S_TRACK) && (r_state != S_LOCKED)) || w_dev_ok);
  assign w_sum_add  = r_sum + c_SUM_W'(i_period_in);
  assign w_sum_roll = r_sum + c_SUM_W'(i_period_in) - c_SUM_W'(w_oldest);

  // State register and all filter datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_wptr         <= '0;
      r_sum          <= '0;
      r_fill         <= '0;
      r_run          <= '0;
      r_miss         <= '0;
      r_timeout      <= '0;
      r_avg          <= '0;
      r_avg_valid    <= 1'b0;
      r_locked       <= 1'b0;
      r_reject_count <= '0;
    end else begin
      r_state        <= w_state_next;
      r_wptr         <= w_wptr_next;
      r_sum          <= w_sum_next;
      r_fill         <= w_fill_next;
      r_run          <= w_run_next;
      r_miss         <= w_miss_next;
      r_timeout      <= w_timeout_next;
      r_avg          <= w_avg_next;
      r_avg_valid    <= w_avg_valid_next;
      r_locked       <= (w_state_next == S_LOCKED);
      r_reject_count <= w_reject_next;
    end
  end

  // Ring buffer write; contents are don't-care until FILL has overwritten all N.
  always_ff @(posedge clock) begin
    if (w_buf_we) begin
      r_buf[r_wptr] <= i_period_in;
    end
  end

  // Next-state and datapath decisions; timeout flush outranks sample handling.
  always_comb begin
    w_state_next     = r_state;
    w_wptr_next      = r_wptr;
    w_sum_next       = r_sum;
    w_fill_next      = r_fill;
    w_run_next       = r_run;
    w_miss_next      = r_miss;
    w_timeout_next   = r_timeout;
    w_avg_next       = r_avg;
    w_avg_valid_next = 1'b0;
    w_reject_next    = r_reject_count;
    w_buf_we         = 1'b0;
    if (!i_period_valid) begin
      if (r_timeout == c_TO_LAST) begin
        w_state_next   = S_IDLE;
        w_wptr_next    = '0;
        w_sum_next     = '0;
        w_fill_next    = '0;
        w_run_next     = '0;
        w_miss_next    = '0;
        w_timeout_next = '0;
        w_avg_next     = '0;
      end else begin
        w_timeout_next = r_timeout + c_TO_W'(1);
      end
    end else begin
      w_timeout_next = '0;
      if (!w_accept) begin
        if (r_reject_count != 16'hFFFF) begin
          w_reject_next = r_reject_count + 16'd1;
        end
        if (r_state == S_TRACK) begin
          w_run_next = '0;
        end else if (r_state == S_LOCKED) begin
          if (r_miss == c_MISS_LAST) begin
            // Too many outliers while locked: discard history and refill.
            w_state_next = S_FILL;
            w_wptr_next  = '0;
            w_sum_next   = '0;
            w_fill_next  = '0;
            w_run_next   = '0;
            w_miss_next  = '0;
            w_avg_next   = '0;
          end else begin
            w_miss_next = r_miss + c_MISS_W'(1);
          end
        end
      end else begin
        w_buf_we    = 1'b1;
        w_wptr_next = r_wptr + AVG_LOG2'(1);
        case (r_state)
          S_IDLE: begin
            w_sum_next   = c_SUM_W'(i_period_in);
            w_fill_next  = c_FILL_W'(1);
            w_state_next = S_FILL;
          end
          S_FILL: begin
            w_sum_next  = w_sum_add;
            w_fill_next = r_fill + c_FILL_W'(1);
            if (r_fill == c_FILL_LAST) begin
              w_state_next     = S_TRACK;
              w_avg_next       = PERIOD_W'(w_sum_add >> AVG_LOG2);
              w_avg_valid_next = 1'b1;
            end
          end
          S_TRACK: begin
            w_sum_next       = w_sum_roll;
            w_avg_next       = PERIOD_W'(w_sum_roll >> AVG_LOG2);
            w_avg_valid_next = 1'b1;
            if (r_run == c_RUN_LAST) begin
              w_state_next = S_LOCKED;
              w_run_next   = '0;
            end else begin
              w_run_next = r_run + c_RUN_W'(1);
            end
          end
          default: begin
            w_sum_next       = w_sum_roll;
            w_avg_next       = PERIOD_W'(w_sum_roll >> AVG_LOG2);
            w_avg_valid_next = 1'b1;
            w_miss_next      = '0;
          end
        endcase
      end
    end
  end

  assign o_avg_valid    = r_avg_valid;
  assign o_avg_period   = r_avg;
  assign o_locked       = r_locked;
  assign o_state        = r_state;
  assign o_reject_count = r_reject_count;

endmodule
`default_nettype wire

// File: tb/tb_period_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_period_filter
//  Description : Directed self-checking bench for period_filter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_period_filter;

  logic        clock;
  logic        reset;
  logic        i_period_valid;
  logic [31:0] i_period_in;
  logic        o_avg_valid;
  logic [31:0] o_avg_period;
  logic        o_locked;
  logic [1:0]  o_state;
  logic [15:0] o_reject_count;

  int tests = 0;
  int fails = 0;

  period_filter dut (
    .clock          (clock),
    .reset          (reset),
    .i_period_valid (i_period_valid),
    .i_period_in    (i_period_in),
    .o_avg_valid    (o_avg_valid),
    .o_avg_period   (o_avg_period),
    .o_locked       (o_locked),
    .o_state        (o_state),
    .o_reject_count (o_reject_count)
  );

  // 10-unit clock; inputs change and outputs are sampled on the falling edge.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; strobe is taken on the next rising edge.
  task automatic send(input logic [31:0] p);
    i_period_valid = 1'b1;
    i_period_in    = p;
    @(negedge clock);
    i_period_valid = 1'b0;
    i_period_in    = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_avg_valid"}, 64'(o_avg_valid), 64'd0);
    check({tag, "_avg"},       64'(o_avg_period), 64'd0);
    check({tag, "_locked"},    64'(o_locked), 64'd0);
    check({tag, "_state"},     64'(o_state), 64'd0);
    check({tag, "_rejects"},   64'(o_reject_count), 64'd0);
  endtask

  // Feed n spaced periods of value p.
  task automatic feed(input int n, input logic [31:0] p);
    for (int k = 0; k < n; k++) begin
      send(p);
      idle(63);
    end
  endtask

  initial begin
    reset          = 1'b1;
    i_period_valid = 1'b0;
    i_period_in    = '0;
    @(negedge clock);
    do_reset();
    check_zero("reset");

    // Acquire at 1000.
    feed(3, 32'd1000);
    check("fill_state", 64'(o_state), 64'd1);
    send(32'd1000);
    check("track_state", 64'(o_state), 64'd2);
    check("track_valid", 64'(o_avg_valid), 64'd1);
    check("track_avg", 64'(o_avg_period), 64'd1000);
    check("track_locked", 64'(o_locked), 64'd0);
    idle(1);
    check("valid_one_cycle", 64'(o_avg_valid), 64'd0);
    idle(62);
    feed(3, 32'd1000);
    check("run3_state", 64'(o_state), 64'd2);
    send(32'd1000);
    check("lock_state", 64'(o_state), 64'd3);
    check("lock_flag", 64'(o_locked), 64'd1);
    idle(63);

    // Tolerance boundary: 125 accepted, 126 rejected.
    send(32'd1126);
    check("dev126_rejects", 64'(o_reject_count), 64'd1);
    check("dev126_avg", 64'(o_avg_period), 64'd1000);
    check("dev126_valid", 64'(o_avg_valid), 64'd0);
    idle(63);
    send(32'd1125);
    check("dev125_avg", 64'(o_avg_period), 64'd1031);
    check("dev125_valid", 64'(o_avg_valid), 64'd1);
    check("dev125_state", 64'(o_state), 64'd3);
    idle(63);

    // Two misses then an accept keeps lock; sum 4125+1031-1000 -> avg 1039.
    feed(2, 32'd2000);
    check("miss2_state", 64'(o_state), 64'd3);
    send(32'd1031);
    check("miss_clear_avg", 64'(o_avg_period), 64'd1039);
    check("miss_clear_state", 64'(o_state), 64'd3);
    idle(63);

    // Three consecutive misses force re-acquire.
    feed(2, 32'd2000);
    check("miss2b_state", 64'(o_state), 64'd3);
    send(32'd2000);
    check("miss3_state", 64'(o_state), 64'd1);
    check("miss3_locked", 64'(o_locked), 64'd0);
    check("miss3_avg", 64'(o_avg_period), 64'd0);
    check("miss3_rejects", 64'(o_reject_count), 64'd6);
    idle(63);

    // Refill from empty: four samples to TRACK, four more to LOCKED.
    feed(3, 32'd1000);
    check("refill_state", 64'(o_state), 64'd1);
    feed(5, 32'd1000);
    check("relock_state", 64'(o_state), 64'd3);

    // Timeout terminal cycle with no strobe flushes; one earlier does not.
    // feed() left 63 idle clocks already; top up to 4095 since the strobe.
    idle(4095 - 63);
    check("to_4095_state", 64'(o_state), 64'd3);
    idle(1);
    check("to_flush_state", 64'(o_state), 64'd0);
    check("to_flush_locked", 64'(o_locked), 64'd0);
    check("to_flush_avg", 64'(o_avg_period), 64'd0);

    // Relock, then a strobe on the terminal cycle prevents the flush.
    feed(8, 32'd1000);
    check("relock2_state", 64'(o_state), 64'd3);
    idle(4095 - 63);
    send(32'd1000);
    check("to_win_state", 64'(o_state), 64'd3);
    check("to_win_valid", 64'(o_avg_valid), 64'd1);
    idle(4095);
    check("to_restart_state", 64'(o_state), 64'd3);

    // Range gate in IDLE, then fill count of 2 proven by the FILL->TRACK edge.
    do_reset();
    check_zero("reset2");
    send(32'd8);
    send(32'd70000);
    check("range_rejects", 64'(o_reject_count), 64'd2);
    check("range_idle", 64'(o_state), 64'd0);
    send(32'd16);
    send(32'd65535);
    check("range_edges_state", 64'(o_state), 64'd1);
    send(32'd16);
    check("range_fill3_state", 64'(o_state), 64'd1);
    send(32'd16);
    check("range_track_state", 64'(o_state), 64'd2);
    check("range_track_avg", 64'(o_avg_period), 64'd16395);
    check("range_track_rejects", 64'(o_reject_count), 64'd2);

    // Reset mid-FILL, then a clean acquire at 500.
    do_reset();
    send(32'd500);
    send(32'd500);
    check("midfill_state", 64'(o_state), 64'd1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check_zero("midfill_reset");
    feed(3, 32'd500);
    send(32'd500);
    check("acq500_avg", 64'(o_avg_period), 64'd500);
    check("acq500_state", 64'(o_state), 64'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
